// File: rtl/z80_bus_responder_if.sv
// Bus bundle between a tv80s-style CPU/host side (master) and the z80_bus_responder (slave).
// Carries the Z80 strobes, address/data, host I/O port and RAM preload signals.
interface z80_bus_responder_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              m1_n;
    logic              mreq_n;
    logic              iorq_n;
    logic              rd_n;
    logic              wr_n;
    logic              rfsh_n;
    logic [15:0]       A;
    logic [7:0]        cpu_dout;
    logic [7:0]        cpu_di;
    logic              wait_n;
    logic [7:0]        io_rd_data;
    logic              io_wr_stb;
    logic [7:0]        io_wr_port;
    logic [7:0]        io_wr_data;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [7:0]        init_data;

    modport master (
        output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, cpu_dout,
        output io_rd_data, init_we, init_addr, init_data,
        input  cpu_di, wait_n, io_wr_stb, io_wr_port, io_wr_data
    );

    modport slave (
        input  m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, cpu_dout,
        input  io_rd_data, init_we, init_addr, init_data,
        output cpu_di, wait_n, io_wr_stb, io_wr_port, io_wr_data
    );
endinterface

// File: rtl/z80_bus_responder.sv
// Target side of tv80s memory, I/O and interrupt-acknowledge cycles: internal byte RAM,
// programmable wait states, one commit per bus cycle and a host-side I/O port.
module z80_bus_responder #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned MEM_WAIT   = 0,
    parameter int unsigned IO_WAIT    = 0,
    parameter logic [7:0]  INTACK_VEC = 8'hFF
) (
    input logic                clk,
    input logic                reset,
    z80_bus_responder_if.slave bus
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StCommit = 2'd2;
    localparam logic [1:0] StHold   = 2'd3;

    localparam logic [1:0] KindMem = 2'd0;
    localparam logic [1:0] KindIo  = 2'd1;
    localparam logic [1:0] KindAck = 2'd2;

    localparam logic [3:0] MemWaitCnt = 4'(MEM_WAIT);
    localparam logic [3:0] IoWaitCnt  = 4'(IO_WAIT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  kind_q, kind_d;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic        blocked_q, blocked_d;
    logic [7:0]  cpu_di_q, cpu_di_d;
    logic        wait_n_q, wait_n_d;
    logic        wr_stb_q, wr_stb_d;
    logic [7:0]  wr_port_q, wr_port_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic [7:0] ram [2**ADDR_W];

    logic              bus_idle;
    logic              strobe;
    logic              det_ack;
    logic              det_io;
    logic              det_mem;
    logic              start;
    logic              commit;
    logic [1:0]        start_kind;
    logic [1:0]        commit_kind;
    logic [3:0]        start_n;
    logic              start_write;
    logic              commit_write;
    logic [15:0]       commit_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic              cpu_mem_we;
    logic              io_we;

    // Start decode; with zero wait states the commit happens on the detection edge itself,
    // so the live bus address is used there and the latched one afterwards.
    always_comb begin
        bus_idle = bus.rd_n & bus.wr_n & bus.mreq_n & bus.iorq_n;
        strobe   = ~bus.rd_n | ~bus.wr_n;
        det_ack  = ~bus.iorq_n & ~bus.m1_n;
        det_io   = ~bus.iorq_n & bus.m1_n & strobe;
        det_mem  = ~bus.mreq_n & bus.rfsh_n & strobe;
        start    = (state_q == StIdle) & ~blocked_q & (det_ack | det_io | det_mem);

        if (det_ack) begin
            start_kind = KindAck;
            start_n    = 4'd0;
        end else if (det_io) begin
            start_kind = KindIo;
            start_n    = IoWaitCnt;
        end else begin
            start_kind = KindMem;
            start_n    = MemWaitCnt;
        end
        start_write = ~det_ack & bus.rd_n;

        commit       = (start & (start_n == 4'd0)) | ((state_q == StWait) & (cnt_q == 4'd0));
        commit_kind  = start ? start_kind : kind_q;
        commit_write = start ? start_write : write_q;
        commit_addr  = start ? bus.A : addr_q;
        ram_addr     = commit_addr[ADDR_W-1:0];
        ram_rdata    = ram[ram_addr];
        cpu_mem_we   = commit & commit_write & (commit_kind == KindMem);
        io_we        = commit & commit_write & (commit_kind == KindIo);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
        write_d   = write_q;
        addr_d    = addr_q;
        cpu_di_d  = cpu_di_q;
        wr_stb_d  = 1'b0;
        wr_port_d = wr_port_q;
        wr_data_d = wr_data_q;
        // Strobes held over from before a reset must drop once before a new start counts.
        blocked_d = blocked_q & ~bus_idle;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    kind_d  = start_kind;
                    write_d = start_write;
                    addr_d  = bus.A;
                    state_d = commit ? StCommit : StWait;
                    cnt_d   = commit ? 4'd0 : start_n - 4'd1;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StCommit;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCommit: state_d = StHold;
            StHold: begin
                if (bus_idle) begin
                    state_d  = StIdle;
                    cpu_di_d = 8'hFF;
                end
            end
            default: state_d = StIdle;
        endcase

        if (commit && !commit_write) begin
            unique case (commit_kind)
                KindMem: cpu_di_d = ram_rdata;
                KindIo:  cpu_di_d = bus.io_rd_data;
                default: cpu_di_d = INTACK_VEC;
            endcase
        end
        if (io_we) begin
            wr_stb_d  = 1'b1;
            wr_port_d = commit_addr[7:0];
            wr_data_d = bus.cpu_dout;
        end

        wait_n_d = (state_d != StWait);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            kind_q    <= KindMem;
            write_q   <= 1'b0;
            addr_q    <= 16'd0;
            blocked_q <= 1'b1;
            cpu_di_q  <= 8'hFF;
            wait_n_q  <= 1'b1;
            wr_stb_q  <= 1'b0;
            wr_port_q <= 8'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            blocked_q <= blocked_d;
            cpu_di_q  <= cpu_di_d;
            wait_n_q  <= wait_n_d;
            wr_stb_q  <= wr_stb_d;
            wr_port_q <= wr_port_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Host preload wins over a CPU write to the same address on the same edge.
    always_ff @(posedge clk) begin
        if (cpu_mem_we && !(bus.init_we && (bus.init_addr == ram_addr))) begin
            ram[ram_addr] <= bus.cpu_dout;
        end
        if (bus.init_we) begin
            ram[bus.init_addr] <= bus.init_data;
        end
    end

    assign bus.cpu_di     = cpu_di_q;
    assign bus.wait_n     = wait_n_q;
    assign bus.io_wr_stb  = wr_stb_q;
    assign bus.io_wr_port = wr_port_q;
    assign bus.io_wr_data = wr_data_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Random Z80 bus cycles driven into two responders with different wait settings, checked
// against a per-address RAM model and the cycle timing rules.
module tb_z80_bus_responder;

    localparam int KMemRd = 0;
    localparam int KMemWr = 1;
    localparam int KIoRd  = 2;
    localparam int KIoWr  = 3;
    localparam int KAck   = 4;
    localparam int KRfsh  = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] pool [16];
    logic [7:0]  mdl  [2][16];

    always #5 clk = ~clk;

    z80_bus_responder_if #(.ADDR_W(16)) bus_a ();
    z80_bus_responder_if #(.ADDR_W(16)) bus_b ();

    assign bus_b.m1_n       = bus_a.m1_n;
    assign bus_b.mreq_n     = bus_a.mreq_n;
    assign bus_b.iorq_n     = bus_a.iorq_n;
    assign bus_b.rd_n       = bus_a.rd_n;
    assign bus_b.wr_n       = bus_a.wr_n;
    assign bus_b.rfsh_n     = bus_a.rfsh_n;
    assign bus_b.A          = bus_a.A;
    assign bus_b.cpu_dout   = bus_a.cpu_dout;
    assign bus_b.io_rd_data = bus_a.io_rd_data;
    assign bus_b.init_we    = bus_a.init_we;
    assign bus_b.init_addr  = bus_a.init_addr;
    assign bus_b.init_data  = bus_a.init_data;

    z80_bus_responder #(
        .ADDR_W(16), .MEM_WAIT(3), .IO_WAIT(1), .INTACK_VEC(8'hE7)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    z80_bus_responder #(
        .ADDR_W(16), .MEM_WAIT(0), .IO_WAIT(2), .INTACK_VEC(8'hE7)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_di(int d);
        return (d == 0) ? bus_a.cpu_di : bus_b.cpu_di;
    endfunction
    function automatic logic get_wait(int d);
        return (d == 0) ? bus_a.wait_n : bus_b.wait_n;
    endfunction
    function automatic logic get_stb(int d);
        return (d == 0) ? bus_a.io_wr_stb : bus_b.io_wr_stb;
    endfunction
    function automatic logic [7:0] get_port(int d);
        return (d == 0) ? bus_a.io_wr_port : bus_b.io_wr_port;
    endfunction
    function automatic logic [7:0] get_wdata(int d);
        return (d == 0) ? bus_a.io_wr_data : bus_b.io_wr_data;
    endfunction

    // Wait states each responder inserts for a cycle kind.
    function automatic int n_for(int d, int kind);
        if (kind == KMemRd || kind == KMemWr) return (d == 0) ? 3 : 0;
        if (kind == KIoRd || kind == KIoWr) return (d == 0) ? 1 : 2;
        return 0;
    endfunction

    task automatic drive_idle();
        bus_a.m1_n    = 1'b1;
        bus_a.mreq_n  = 1'b1;
        bus_a.iorq_n  = 1'b1;
        bus_a.rd_n    = 1'b1;
        bus_a.wr_n    = 1'b1;
        bus_a.rfsh_n  = 1'b1;
        bus_a.init_we = 1'b0;
    endtask

    task automatic preload(input int idx, input logic [7:0] data);
        @(negedge clk);
        bus_a.init_we   = 1'b1;
        bus_a.init_addr = pool[idx];
        bus_a.init_data = data;
        @(negedge clk);
        bus_a.init_we = 1'b0;
        mdl[0][idx] = data;
        mdl[1][idx] = data;
    endtask

    task automatic check_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("%s d%0d di", tag, d), 16'(get_di(d)), 16'hFF);
            check_val($sformatf("%s d%0d wait", tag, d), 16'(get_wait(d)), 16'd1);
            check_val($sformatf("%s d%0d stb", tag, d), 16'(get_stb(d)), 16'd0);
        end
    endtask

    // One bus cycle: strobes low for len samples, optional host preload on edge c after detection.
    task automatic run_txn(input int t, input int kind, input int idx, input logic [7:0] wdata,
                           input logic m1, input logic [7:0] iodata, input int len,
                           input bit init_on, input int c, input int ia, input logic [7:0] id);
        int         n [2];
        logic [7:0] rexp [2];
        bit         active;
        bit         rd;
        bit         iow;
        active = (kind != KRfsh);
        rd     = (kind == KMemRd) || (kind == KIoRd) || (kind == KAck);
        iow    = (kind == KIoWr);
        for (int d = 0; d < 2; d++) begin
            n[d] = n_for(d, kind);
            case (kind)
                KMemRd:  rexp[d] = (init_on && ia == idx && c < n[d]) ? id : mdl[d][idx];
                KIoRd:   rexp[d] = iodata;
                KAck:    rexp[d] = 8'hE7;
                default: rexp[d] = 8'hFF;
            endcase
        end

        @(negedge clk);
        bus_a.A          = pool[idx];
        bus_a.cpu_dout   = wdata;
        bus_a.io_rd_data = iodata;
        bus_a.init_addr  = pool[ia];
        bus_a.init_data  = id;
        bus_a.init_we    = init_on && (c == 0);
        case (kind)
            KMemRd: begin bus_a.m1_n = m1; bus_a.mreq_n = 1'b0; bus_a.rd_n = 1'b0; end
            KMemWr: begin bus_a.mreq_n = 1'b0; bus_a.wr_n = 1'b0; end
            KIoRd:  begin bus_a.iorq_n = 1'b0; bus_a.rd_n = 1'b0; end
            KIoWr:  begin bus_a.iorq_n = 1'b0; bus_a.wr_n = 1'b0; end
            KAck:   begin bus_a.m1_n = 1'b0; bus_a.iorq_n = 1'b0; end
            default: begin bus_a.mreq_n = 1'b0; bus_a.rfsh_n = 1'b0; end
        endcase

        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            bus_a.init_we = 1'b0;
            for (int d = 0; d < 2; d++) begin
                check_val($sformatf("t%0d d%0d s%0d wait", t, d, j), 16'(get_wait(d)),
                          16'(!(active && j <= n[d])));
                check_val($sformatf("t%0d d%0d s%0d di", t, d, j), 16'(get_di(d)),
                          16'((rd && j > n[d]) ? rexp[d] : 8'hFF));
                check_val($sformatf("t%0d d%0d s%0d stb", t, d, j), 16'(get_stb(d)),
                          16'(iow && j == n[d] + 1));
                if (iow && j == n[d] + 1) begin
                    check_val($sformatf("t%0d d%0d port", t, d), 16'(get_port(d)),
                              16'(pool[idx][7:0]));
                    check_val($sformatf("t%0d d%0d wdata", t, d), 16'(get_wdata(d)), 16'(wdata));
                end
            end
            if (j < len) bus_a.init_we = init_on && (c == j);
        end
        drive_idle();
        @(negedge clk);
        check_quiet($sformatf("t%0d end", t));

        for (int d = 0; d < 2; d++) begin
            if (kind == KMemWr && init_on && ia == idx && c < n[d]) begin
                mdl[d][ia]  = id;
                mdl[d][idx] = wdata;
            end else begin
                if (kind == KMemWr) mdl[d][idx] = wdata;
                if (init_on) mdl[d][ia] = id;
            end
        end
    endtask

    // Write 0x77 to 0x0100, reset during responder A's second wait cycle.
    task automatic reset_mid_write();
        @(negedge clk);
        bus_a.A        = pool[3];
        bus_a.cpu_dout = 8'h77;
        bus_a.mreq_n   = 1'b0;
        bus_a.wr_n     = 1'b0;
        @(negedge clk);
        check_val("rst w1", 16'(get_wait(0)), 16'd0);
        @(negedge clk);
        check_val("rst w2", 16'(get_wait(0)), 16'd0);
        reset = 1'b1;
        #1;
        check_quiet("rst now");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_quiet("rst held");
        end
        drive_idle();
        @(negedge clk);
        mdl[1][3] = 8'h77;
    endtask

    initial begin
        int t;
        reset = 1'b1;
        drive_idle();
        bus_a.A          = 16'd0;
        bus_a.cpu_dout   = 8'd0;
        bus_a.io_rd_data = 8'd0;
        bus_a.init_addr  = 16'd0;
        bus_a.init_data  = 8'd0;
        pool[0] = 16'h0000;
        pool[1] = 16'h1234;
        pool[2] = 16'h1010;
        pool[3] = 16'h0100;
        pool[4] = 16'h0200;
        for (int i = 5; i < 16; i++) pool[i] = {4'(i), 12'($urandom)};

        repeat (3) @(negedge clk);
        check_quiet("reset");
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("reset d%0d port", d), 16'(get_port(d)), 16'd0);
            check_val($sformatf("reset d%0d wdata", d), 16'(get_wdata(d)), 16'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        preload(0, 8'h14);
        preload(1, 8'h00);
        preload(2, 8'hC3);
        preload(3, 8'h42);
        preload(4, 8'h11);
        for (int i = 5; i < 16; i++) preload(i, 8'($urandom));

        run_txn(1, KMemRd, 0, 8'h00, 1'b0, 8'h00, 5, 1'b0, 0, 0, 8'h00);
        run_txn(2, KMemWr, 1, 8'hA5, 1'b1, 8'h00, 5, 1'b0, 0, 0, 8'h00);
        run_txn(3, KMemRd, 1, 8'h00, 1'b1, 8'h00, 5, 1'b0, 0, 0, 8'h00);
        run_txn(4, KIoWr, 2, 8'h3C, 1'b1, 8'h00, 5, 1'b0, 0, 0, 8'h00);
        run_txn(5, KMemRd, 2, 8'h00, 1'b1, 8'h00, 5, 1'b0, 0, 0, 8'h00);
        run_txn(6, KIoRd, 2, 8'h00, 1'b1, 8'h5A, 5, 1'b0, 0, 0, 8'h00);
        run_txn(7, KRfsh, 0, 8'h00, 1'b1, 8'h00, 5, 1'b0, 0, 0, 8'h00);
        run_txn(8, KAck, 0, 8'h00, 1'b0, 8'h00, 5, 1'b0, 0, 0, 8'h00);
        reset_mid_write();
        run_txn(9, KMemRd, 3, 8'h00, 1'b1, 8'h00, 5, 1'b0, 0, 0, 8'h00);
        run_txn(10, KMemWr, 3, 8'h55, 1'b1, 8'h00, 6, 1'b1, 3, 3, 8'h99);
        run_txn(11, KMemRd, 3, 8'h00, 1'b1, 8'h00, 5, 1'b0, 0, 0, 8'h00);
        run_txn(12, KMemWr, 4, 8'h55, 1'b1, 8'h00, 6, 1'b1, 0, 4, 8'h99);
        run_txn(13, KMemRd, 4, 8'h00, 1'b1, 8'h00, 5, 1'b0, 0, 0, 8'h00);

        for (t = 100; t < 180; t++) begin
            int len;
            bit init_on;
            len     = int'($urandom_range(5, 7));
            init_on = ($urandom_range(0, 2) == 0);
            run_txn(t, int'($urandom_range(0, 5)), int'($urandom_range(0, 15)), 8'($urandom),
                    1'($urandom), 8'($urandom), len, init_on,
                    int'($urandom_range(0, len - 1)), int'($urandom_range(0, 15)), 8'($urandom));
        end
        for (int i = 0; i < 16; i++) begin
            run_txn(200 + i, KMemRd, i, 8'h00, 1'b1, 8'h00, 5, 1'b0, 0, 0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
Synthesizable slave on the tv80s Z80 bus, the target side of CPU memory, I/O and interrupt-acknowledge cycles. Decodes mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n and serves reads from an internal byte RAM. Commits writes exactly once per bus cycle and forwards I/O traffic to a host-side port. Inserts a programmable number of wait states via wait_n. Replaces behavioural negedge memory models in CPU benches and FPGA builds.

Parameters:
ADDR_W, 16, RAM address width; RAM depth 2^ADDR_W; A[ADDR_W-1:0] used, upper bits alias.
MEM_WAIT, 0, wait cycles inserted on memory read/write cycles (0..15).
IO_WAIT, 0, wait cycles inserted on I/O read/write cycles (0..15).
INTACK_VEC, 8'hFF, byte driven during interrupt acknowledge (m1_n=0, iorq_n=0).

Ports:
clk  in  1  system clock, same clock as tv80s clk; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
m1_n  in  1  CPU M1.
mreq_n  in  1  CPU memory request.
iorq_n  in  1  CPU I/O request.
rd_n  in  1  CPU read strobe.
wr_n  in  1  CPU write strobe.
rfsh_n  in  1  CPU refresh.
A  in  16  CPU address.
cpu_dout  in  8  CPU write data.
cpu_di  out  8  read data to CPU.
wait_n  out  1  wait request to CPU, active low.
io_rd_data  in  8  host-supplied byte for I/O reads, sampled at commit.
io_wr_stb  out  1  one-cycle pulse on I/O write commit.
io_wr_port  out  8  A[7:0] of committed I/O write.
io_wr_data  out  8  data of committed I/O write.
init_we  in  1  host RAM preload write enable.
init_addr  in  ADDR_W  preload address.
init_data  in  8  preload data.

Behaviour:
- Reset (async): state=IDLE, cpu_di=8'hFF, wait_n=1, io_wr_stb=0, io_wr_port=0, io_wr_data=0, wait counter=0. RAM contents are not reset.
- Start detection, sampled at rising clk in IDLE:
  - MEM: mreq_n=0, rfsh_n=1, rd_n=0 or wr_n=0.
  - IO: iorq_n=0, m1_n=1, rd_n=0 or wr_n=0.
  - ACK: iorq_n=0, m1_n=0.
  - Refresh (mreq_n=0, rfsh_n=0) and all other combinations are ignored.
  - Priority: ACK > IO > MEM.
  - Access kind (read/write), address and type latch at detection.
- States:
  - IDLE -> WAIT when N>0, where N=MEM_WAIT for MEM, IO_WAIT for IO, 0 for ACK.
  - IDLE -> COMMIT when N=0.
  - WAIT -> COMMIT after exactly N cycles.
  - COMMIT -> HOLD unconditionally (1 cycle).
  - HOLD -> IDLE on the first cycle with rd_n=1, wr_n=1, mreq_n=1, iorq_n=1.
- wait_n: registered. Low for exactly N consecutive cycles, starting the cycle after detection. Never low when N=0. Forced 1 in IDLE/COMMIT/HOLD.
- Read commit, at the COMMIT edge:
  - MEM: cpu_di <= RAM[A].
  - IO: cpu_di <= io_rd_data.
  - ACK: cpu_di <= INTACK_VEC.
  - cpu_di holds through HOLD and returns to 8'hFF on entering IDLE.
  - Read latency: data valid 1 cycle after detection + N.
- Write commit, at the COMMIT edge:
  - MEM: RAM[A] <= cpu_dout, written once even though wr_n spans several cycles.
  - IO: io_wr_stb=1 for exactly one cycle with port/data; RAM is not touched.
  - cpu_di stays 8'hFF.
- Back-to-back cycles: a new start is accepted only from IDLE, so strobes must deassert for at least 1 cycle between cycles. tv80s always does this.
- init_we: writes RAM on any rising edge, independent of state and reset. If it coincides with a CPU MEM write commit to the same address, init_data wins. The CPU commit is dropped only for that address.
- Reset mid-cycle (WAIT/COMMIT/HOLD): outputs go to reset values immediately. A write not yet committed is discarded. Strobes still low after reset release are ignored until they deassert.

Test Plan:
1. Preload RAM[0x0000]=0x14, MEM_WAIT=0; M1 read of 0x0000 -> cpu_di=0x14 one cycle after detection; wait_n stays 1; cpu_di=0xFF after strobes rise.
2. MEM_WAIT=2; write 0xA5 to 0x1234 with wr_n low 4 cycles -> wait_n low exactly 2 cycles; RAM[0x1234]=0xA5 written once; subsequent read returns 0xA5.
3. IO write port 0x10, data 0x3C, IO_WAIT=1 -> wait_n low 1 cycle; single io_wr_stb pulse with io_wr_port=0x10, io_wr_data=0x3C; RAM[0x1010] unchanged.
4. IO read with io_rd_data=0x5A -> cpu_di=0x5A at commit. Refresh cycle (mreq_n=0, rfsh_n=0, rd_n=1) -> no state change, cpu_di=0xFF, wait_n=1.
5. Interrupt ack (m1_n=0, iorq_n=0), INTACK_VEC=0xE7 -> cpu_di=0xE7; no io_wr_stb; no RAM change.
6. MEM_WAIT=3; assert reset during 2nd wait cycle of write 0x77 to 0x0100 -> wait_n=1 and cpu_di=0xFF immediately; RAM[0x0100] keeps its old value. Same-cycle init_we to 0x0100 with 0x99 during a CPU commit to 0x0100 -> RAM=0x99.
